// File: rtl/alu_issue_decoder_if.sv
// Instruction-in / decoded-slot-out stream bundle for the ALU issue decoder.
// master = fetch/execute side that drives words and consumes slots,
// slave  = the decoder itself.
interface alu_issue_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_rd_we;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_rd_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_rd_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_decoder.sv
// RV32I ALU-subset decoder with a single registered output slot.
// Decode is purely combinational on the incoming word and only reaches the
// outputs through the slot register, so execute sees no in_instr timing path.
module alu_issue_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_decoder_if.slave bus,
  output logic [CNT_W-1:0] accept_cnt
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_legal;
  logic        dec_use_imm;
  logic        dec_shift;
  logic [3:0]  dec_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs2;
  logic        dec_rd_we;
  logic        accept;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // Slot can take a new word when empty or when it is draining this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Classify the incoming word; anything unmatched stays illegal with ADD.
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_shift   = 1'b0;
    dec_op      = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
            3'b001: begin dec_legal = 1'b1; dec_op = ALU_SLL; end
            3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
            3'b101: begin dec_legal = 1'b1; dec_op = ALU_SRL; end
            3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
            3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_AND; end
          3'b001: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1; dec_use_imm = 1'b1; dec_shift = 1'b1; dec_op = ALU_SLL;
            end
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1; dec_use_imm = 1'b1; dec_shift = 1'b1; dec_op = ALU_SRL;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Shift immediates carry only the 5-bit shamt; everything else sign-extends.
  assign dec_imm   = dec_shift ? {27'd0, bus.in_instr[24:20]}
                               : {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign dec_rs2   = dec_use_imm ? 5'd0 : bus.in_instr[24:20];
  assign dec_rd_we = dec_legal && (bus.in_instr[11:7] != 5'd0);

  // Slot register: flush kills, accept loads, consume empties, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_alu_op  <= ALU_ADD;
      bus.out_rs1     <= 5'd0;
      bus.out_rs2     <= 5'd0;
      bus.out_rd      <= 5'd0;
      bus.out_imm     <= 32'd0;
      bus.out_use_imm <= 1'b0;
      bus.out_rd_we   <= 1'b0;
      bus.out_illegal <= 1'b0;
      accept_cnt      <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_alu_op  <= dec_op;
      bus.out_rs1     <= bus.in_instr[19:15];
      bus.out_rs2     <= dec_rs2;
      bus.out_rd      <= bus.in_instr[11:7];
      bus.out_imm     <= dec_imm;
      bus.out_use_imm <= dec_use_imm;
      bus.out_rd_we   <= dec_rd_we;
      bus.out_illegal <= !dec_legal;
      accept_cnt      <= accept_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench for alu_issue_decoder: directed vector table, hand
// sequences for stall/flush/async reset/counter wrap, and random traffic
// checked against a mask/match reference decoder with a one-slot model.
module tb_alu_issue_decoder;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        we;
    logic        ill;
  } slot_t;

  typedef struct {
    logic [31:0] instr;
    slot_t       exp;
  } vec_t;

  // Supported subset as mask/match pairs; kind 0=reg, 1=imm, 2=shift-imm.
  localparam logic [31:0] LT_MASK [13] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'h0000707F, 32'hFE00707F, 32'hFE00707F};
  localparam logic [31:0] LT_MATCH [13] = '{
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00004033, 32'h00005033,
    32'h00006033, 32'h00007033, 32'h00000013, 32'h00004013, 32'h00006013,
    32'h00007013, 32'h00001013, 32'h00005013};
  localparam logic [3:0] LT_OP [13] = '{
    4'd0, 4'd1, 4'd5, 4'd4, 4'd6, 4'd3, 4'd2, 4'd0, 4'd4, 4'd3, 4'd2, 4'd5, 4'd6};
  localparam int LT_KIND [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2};

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] accept_cnt;

  alu_issue_decoder_if bus ();

  alu_issue_decoder #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_valid;
  slot_t       m_slot;
  logic [15:0] m_cnt;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic slot_t mk(logic [3:0] op, int rs1, int rs2, int rd, logic [31:0] imm,
                               logic use_imm, logic we, logic ill);
    slot_t s;
    s.op = op; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.imm = imm; s.use_imm = use_imm; s.we = we; s.ill = ill;
    return s;
  endfunction

  function automatic slot_t ref_decode(logic [31:0] w);
    slot_t s;
    int hit;
    hit = -1;
    for (int k = 0; k < 13; k++)
      if ((w & LT_MASK[k]) == LT_MATCH[k]) hit = k;
    s.rs1 = w[19:15];
    s.rd  = w[11:7];
    s.imm = {{20{w[31]}}, w[31:20]};
    if (hit < 0) begin
      s.ill = 1'b1; s.op = 4'd0; s.use_imm = 1'b0;
    end else begin
      s.ill = 1'b0; s.op = LT_OP[hit]; s.use_imm = (LT_KIND[hit] != 0);
      if (LT_KIND[hit] == 2) s.imm = {27'd0, w[24:20]};
    end
    s.rs2 = s.use_imm ? 5'd0 : w[24:20];
    s.we  = !s.ill && (w[11:7] != 5'd0);
    return s;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int idx;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: begin
        idx = $urandom_range(0, 12);
        return (r & ~LT_MASK[idx]) | LT_MATCH[idx];
      end
      2: return {($urandom_range(0, 1) == 0) ? 7'd0 : r[31:25], r[24:7], 7'b0110011};
      default: return {($urandom_range(0, 1) == 0) ? 7'd0 : r[31:25], r[24:7], 7'b0010011};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_slot  = mk(4'd0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    m_cnt   = 16'd0;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
    chk({tag, "_valid"},    32'(bus.out_valid), 32'(m_valid));
    chk({tag, "_op"},       32'(bus.out_alu_op), 32'(m_slot.op));
    chk({tag, "_rs1"},      32'(bus.out_rs1), 32'(m_slot.rs1));
    chk({tag, "_rs2"},      32'(bus.out_rs2), 32'(m_slot.rs2));
    chk({tag, "_rd"},       32'(bus.out_rd), 32'(m_slot.rd));
    chk({tag, "_imm"},      bus.out_imm, m_slot.imm);
    chk({tag, "_use_imm"},  32'(bus.out_use_imm), 32'(m_slot.use_imm));
    chk({tag, "_rd_we"},    32'(bus.out_rd_we), 32'(m_slot.we));
    chk({tag, "_illegal"},  32'(bus.out_illegal), 32'(m_slot.ill));
    chk({tag, "_cnt"},      32'(accept_cnt), 32'(m_cnt));
  endtask

  // One clock: decide the transfer from the pre-edge inputs, then advance the model.
  task automatic tick();
    logic acc;
    acc = bus.in_valid && (!m_valid || bus.out_ready) && !flush;
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_slot  = ref_decode(bus.in_instr);
      m_valid = 1'b1;
      m_cnt   = m_cnt + 16'd1;
    end else if (m_valid && bus.out_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] w, logic ordy, logic fl);
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  vec_t vecs [19];

  initial begin
    logic [15:0] cnt_before;

    vecs[0]  = '{32'h002081B3, mk(4'd0, 1, 2, 3, 32'h2, 0, 1, 0)};
    vecs[1]  = '{32'hFFF00093, mk(4'd0, 0, 0, 1, 32'hFFFFFFFF, 1, 1, 0)};
    vecs[2]  = '{32'h4010D093, mk(4'd0, 1, 1, 1, 32'h401, 0, 0, 1)};
    vecs[3]  = '{32'h0050D093, mk(4'd6, 1, 0, 1, 32'h5, 1, 1, 0)};
    vecs[4]  = '{32'h00000033, mk(4'd0, 0, 0, 0, 32'h0, 0, 0, 0)};
    vecs[5]  = '{32'h40208133, mk(4'd1, 1, 2, 2, 32'h402, 0, 1, 0)};
    vecs[6]  = '{enc_r(7'h00, 5'd7, 5'd6, 3'b100, 5'd5), mk(4'd4, 6, 7, 5, 32'h7, 0, 1, 0)};
    vecs[7]  = '{enc_r(7'h00, 5'd3, 5'd2, 3'b010, 5'd4), mk(4'd0, 2, 3, 4, 32'h3, 0, 0, 1)};
    vecs[8]  = '{enc_r(7'h00, 5'd9, 5'd8, 3'b001, 5'd10), mk(4'd5, 8, 9, 10, 32'h9, 0, 1, 0)};
    vecs[9]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'b110, 5'd31), mk(4'd3, 2, 1, 31, 32'h1, 0, 1, 0)};
    vecs[10] = '{enc_r(7'h00, 5'd4, 5'd5, 3'b111, 5'd6), mk(4'd2, 5, 4, 6, 32'h4, 0, 1, 0)};
    vecs[11] = '{enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3), mk(4'd0, 1, 2, 3, 32'h402, 0, 0, 1)};
    vecs[12] = '{enc_i(12'h800, 5'd7, 3'b111, 5'd8), mk(4'd2, 7, 0, 8, 32'hFFFFF800, 1, 1, 0)};
    vecs[13] = '{enc_i(12'h7FF, 5'd1, 3'b110, 5'd2), mk(4'd3, 1, 0, 2, 32'h7FF, 1, 1, 0)};
    vecs[14] = '{enc_i(12'h123, 5'd3, 3'b100, 5'd0), mk(4'd4, 3, 0, 0, 32'h123, 1, 0, 0)};
    vecs[15] = '{enc_i(12'h01F, 5'd4, 3'b001, 5'd5), mk(4'd5, 4, 0, 5, 32'h1F, 1, 1, 0)};
    vecs[16] = '{enc_i(12'h41F, 5'd4, 3'b001, 5'd5), mk(4'd0, 4, 31, 5, 32'h41F, 0, 0, 1)};
    vecs[17] = '{32'h000012B7, mk(4'd0, 0, 0, 5, 32'h0, 0, 0, 1)};
    vecs[18] = '{enc_r(7'h20, 5'd1, 5'd1, 3'b100, 5'd1), mk(4'd0, 1, 1, 1, 32'h401, 0, 0, 1)};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_model("reset");
    rst_n = 1'b1;

    // Directed vector table, one word per cycle at full throughput
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, vecs[i].instr, 1'b1, 1'b0);
      #1;
      tick();
      chk($sformatf("vec%0d_valid", i),   32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_op", i),      32'(bus.out_alu_op), 32'(vecs[i].exp.op));
      chk($sformatf("vec%0d_rs1", i),     32'(bus.out_rs1), 32'(vecs[i].exp.rs1));
      chk($sformatf("vec%0d_rs2", i),     32'(bus.out_rs2), 32'(vecs[i].exp.rs2));
      chk($sformatf("vec%0d_rd", i),      32'(bus.out_rd), 32'(vecs[i].exp.rd));
      chk($sformatf("vec%0d_imm", i),     bus.out_imm, vecs[i].exp.imm);
      chk($sformatf("vec%0d_use_imm", i), 32'(bus.out_use_imm), 32'(vecs[i].exp.use_imm));
      chk($sformatf("vec%0d_rd_we", i),   32'(bus.out_rd_we), 32'(vecs[i].exp.we));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].exp.ill));
      chk($sformatf("vec%0d_cnt", i),     32'(accept_cnt), 32'(i + 1));
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #1; tick();
    check_model("drain");

    // Stall: sub held while out_ready=0 with a pending word
    drive(1'b1, 32'h40208133, 1'b1, 1'b0);
    #1; tick();
    cnt_before = accept_cnt;
    drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_op", 32'(bus.out_alu_op), 32'd1);
      check_model("stall");
      tick();
    end
    chk("stall_cnt_held", 32'(accept_cnt), 32'(cnt_before));
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("release_op", 32'(bus.out_alu_op), 32'd0);
    chk("release_rd", 32'(bus.out_rd), 32'd3);
    chk("release_cnt", 32'(accept_cnt), 32'(cnt_before + 16'd1));
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #1; tick();
    check_model("post_release");

    // Flush with a valid, stalled slot and a same-cycle word
    drive(1'b1, 32'h0050D093, 1'b1, 1'b0);
    #1; tick();
    cnt_before = accept_cnt;
    drive(1'b1, 32'h002081B3, 1'b0, 1'b1);
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_cnt", 32'(accept_cnt), 32'(cnt_before));
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #1;
    check_model("flush");

    // Async reset between edges while the slot is full
    drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
    #1; tick();
    chk("areset_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_valid", 32'(bus.out_valid), 32'd0);
    chk("areset_cnt", 32'(accept_cnt), 32'd0);
    check_model("areset");
    #1;
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      #1;
      check_model("rnd");
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #1;
    check_model("rnd_end");

    // Counter wrap after 2^16 accepted words from a fresh reset
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h00A50533, 1'b1, 1'b0);
    for (int c = 0; c < 65535; c++) tick();
    chk("wrap_pre_cnt", 32'(accept_cnt), 32'h0000FFFF);
    tick();
    chk("wrap_cnt", 32'(accept_cnt), 32'd0);
    check_model("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
